v_regfile: RTL and testbench



---
 rtl/v_regfile_pkg.sv | 14 +
 rtl/v_regfile_rport.sv | 53 +++++
 rtl/v_regfile.sv | 95 +++++++++
 tb/tb_v_regfile.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/v_regfile_pkg.sv
// Shared sizes and types for the vector register file and its read ports.
package v_regfile_pkg;

  localparam int VREG_NUM   = 32;
  localparam int VREG_WIDTH = 256;
  localparam int VLANE_BITS = 32;
  localparam int VLMAX      = VREG_WIDTH / VLANE_BITS;
  localparam int VREG_AW    = $clog2(VREG_NUM);

  typedef logic [VREG_WIDTH-1:0] vreg_t;
  typedef logic [VREG_AW-1:0]    vreg_addr_t;
  typedef logic [VLMAX-1:0]      vlane_mask_t;

endpackage

// File: rtl/v_regfile_rport.sv
// One combinational read port: array lookup, lane-wise forwarding of the
// in-flight write, and busy suppression when that write retires the operand.
module v_regfile_rport
  import v_regfile_pkg::*;
#(
  parameter int NREG = VREG_NUM,
  parameter int VLEN = VREG_WIDTH,
  parameter int SEW  = VLANE_BITS,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                rst,
  input  logic [VLEN-1:0]     mem [NREG],
  input  logic [NREG-1:0]     busy,
  input  logic [AW-1:0]       raddr,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic [VLEN-1:0]     wdata,
  input  logic [VLEN/SEW-1:0] wmask,
  output logic [VLEN-1:0]     rdata,
  output logic                rbusy
);

  localparam int LANES = VLEN / SEW;

  logic            hit;
  logic [VLEN-1:0] bit_mask;

  // NOTE: every combinational output gets a default before any condition,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    bit_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      bit_mask[k*SEW +: SEW] = {SEW{wmask[k]}};
    end
  end

  assign hit = wen && (raddr == waddr);

  always_comb begin
    rdata = mem[raddr];
    rbusy = busy[raddr];
    if (hit) begin
      rdata = (rdata & ~bit_mask) | (wdata & bit_mask);
      // Any write retires the producer, even one with an empty lane mask.
      rbusy = 1'b0;
    end
    if (rst) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/v_regfile.sv
// Vector register file: 32 x 256-bit array, two forwarding read ports, one
// lane-masked write port and a per-register busy scoreboard for RAW stalls.
module v_regfile
  import v_regfile_pkg::*;
#(
  parameter int NREG = VREG_NUM,
  parameter int VLEN = VREG_WIDTH,
  parameter int SEW  = VLANE_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(NREG)-1:0]    vs1_raddr_i,
  output logic [VLEN-1:0]            vs1_rdata_o,
  input  logic [$clog2(NREG)-1:0]    vs2_raddr_i,
  output logic [VLEN-1:0]            vs2_rdata_o,
  output logic                       vs1_busy_o,
  output logic                       vs2_busy_o,
  input  logic                       wen_i,
  input  logic [$clog2(NREG)-1:0]    waddr_i,
  input  logic [VLEN-1:0]            wdata_i,
  input  logic [VLEN/SEW-1:0]        wmask_i,
  input  logic                       issue_valid_i,
  input  logic [$clog2(NREG)-1:0]    issue_vd_i,
  output logic [NREG-1:0]            busy_o
);

  localparam int AW    = $clog2(NREG);
  localparam int LANES = VLEN / SEW;

  logic [VLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [VLEN-1:0] wbits;

  always_comb begin
    wbits = '0;
    for (int k = 0; k < LANES; k++) begin
      wbits[k*SEW +: SEW] = {SEW{wmask_i[k]}};
    end
  end

  // Clear first, then set, so a new producer issuing in the retiring cycle
  // keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (wen_i)         busy_next[waddr_i]    = 1'b0;
    if (issue_valid_i) busy_next[issue_vd_i] = 1'b1;
  end

  // NOTE: the whole array is reset because software relies on every vector
  // register reading 0 after reset, not just the scoreboard. Sequential state
  // uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        mem[r] <= '0;
      end
      busy <= '0;
    end else begin
      if (wen_i) begin
        mem[waddr_i] <= (mem[waddr_i] & ~wbits) | (wdata_i & wbits);
      end
      busy <= busy_next;
    end
  end

  assign busy_o = busy;

  v_regfile_rport #(.NREG(NREG), .VLEN(VLEN), .SEW(SEW), .AW(AW)) u_rport_vs1 (
    .rst   (rst),
    .mem   (mem),
    .busy  (busy),
    .raddr (vs1_raddr_i),
    .wen   (wen_i),
    .waddr (waddr_i),
    .wdata (wdata_i),
    .wmask (wmask_i),
    .rdata (vs1_rdata_o),
    .rbusy (vs1_busy_o)
  );

  v_regfile_rport #(.NREG(NREG), .VLEN(VLEN), .SEW(SEW), .AW(AW)) u_rport_vs2 (
    .rst   (rst),
    .mem   (mem),
    .busy  (busy),
    .raddr (vs2_raddr_i),
    .wen   (wen_i),
    .waddr (waddr_i),
    .wdata (wdata_i),
    .wmask (wmask_i),
    .rdata (vs2_rdata_o),
    .rbusy (vs2_busy_o)
  );

endmodule

// File: tb/tb_v_regfile.sv
// Directed self-checking bench for v_regfile: reset, writes, masking,
// forwarding, scoreboard and asynchronous reset mid-stream.
module tb_v_regfile;
  import v_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  vs1_raddr_i, vs2_raddr_i, waddr_i, issue_vd_i;
  logic [255:0] vs1_rdata_o, vs2_rdata_o, wdata_i;
  logic        vs1_busy_o, vs2_busy_o, wen_i, issue_valid_i;
  logic [7:0]  wmask_i;
  logic [31:0] busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  v_regfile dut (
    .clk           (clk),
    .rst           (rst),
    .vs1_raddr_i   (vs1_raddr_i),
    .vs1_rdata_o   (vs1_rdata_o),
    .vs2_raddr_i   (vs2_raddr_i),
    .vs2_rdata_o   (vs2_rdata_o),
    .vs1_busy_o    (vs1_busy_o),
    .vs2_busy_o    (vs2_busy_o),
    .wen_i         (wen_i),
    .waddr_i       (waddr_i),
    .wdata_i       (wdata_i),
    .wmask_i       (wmask_i),
    .issue_valid_i (issue_valid_i),
    .issue_vd_i    (issue_vd_i),
    .busy_o        (busy_o)
  );

  function automatic logic [255:0] splat(input logic [31:0] w);
    return {8{w}};
  endfunction

  // Advance past the next rising edge and let outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen_i = 1'b0; issue_valid_i = 1'b0; wmask_i = 8'h00;
    waddr_i = '0; wdata_i = '0; issue_vd_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    vs1_raddr_i = 5'd0; vs2_raddr_i = 5'd31;
    // A write asserted during reset must neither forward nor land.
    wen_i = 1'b1; waddr_i = 5'd0; wdata_i = splat(32'hFFFF_FFFF); wmask_i = 8'hFF;
    #1;
    total++;
    if (vs1_rdata_o !== '0) begin bad++; $display("FAIL reset_vs1_rdata got=%h want=0", vs1_rdata_o); end
    total++;
    if (vs2_rdata_o !== '0) begin bad++; $display("FAIL reset_vs2_rdata got=%h want=0", vs2_rdata_o); end
    total++;
    if (busy_o !== 32'h0 || vs1_busy_o !== 1'b0 || vs2_busy_o !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%h/%b/%b want=0/0/0", busy_o, vs1_busy_o, vs2_busy_o);
    end
    step();
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    total++;
    if (vs1_rdata_o !== '0) begin bad++; $display("FAIL reset_v0_after got=%h want=0", vs1_rdata_o); end
  endtask

  task automatic test_full_write();
    logic [255:0] exp;
    for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'(k + 1);
    wen_i = 1'b1; waddr_i = 5'd5; wdata_i = exp; wmask_i = 8'hFF;
    step();
    idle();
    vs1_raddr_i = 5'd5; vs2_raddr_i = 5'd5;
    #1;
    total++;
    if (vs1_rdata_o !== exp) begin bad++; $display("FAIL full_vs1 got=%h want=%h", vs1_rdata_o, exp); end
    total++;
    if (vs2_rdata_o !== exp) begin bad++; $display("FAIL full_vs2 got=%h want=%h", vs2_rdata_o, exp); end
  endtask

  task automatic test_masked_write();
    logic [255:0] exp;
    exp = {32'd8, 32'd7, 32'd6, 32'd5, {4{32'hDEAD_BEEF}}};
    wen_i = 1'b1; waddr_i = 5'd5; wdata_i = splat(32'hDEAD_BEEF); wmask_i = 8'h0F;
    step();
    idle();
    vs1_raddr_i = 5'd5;
    #1;
    total++;
    if (vs1_rdata_o !== exp) begin bad++; $display("FAIL masked got=%h want=%h", vs1_rdata_o, exp); end
  endtask

  task automatic test_forwarding();
    logic [255:0] exp_fwd, exp_v5;
    exp_fwd = {{4{32'h11}}, {4{32'h22}}};
    exp_v5  = {32'd8, 32'd7, 32'd6, 32'd5, {4{32'hDEAD_BEEF}}};
    wen_i = 1'b1; waddr_i = 5'd7; wdata_i = splat(32'h22); wmask_i = 8'hFF;
    step();
    wen_i = 1'b1; waddr_i = 5'd7; wdata_i = splat(32'h11); wmask_i = 8'hF0;
    vs1_raddr_i = 5'd7; vs2_raddr_i = 5'd5;
    #1;
    total++;
    if (vs1_rdata_o !== exp_fwd) begin bad++; $display("FAIL fwd_same_cycle got=%h want=%h", vs1_rdata_o, exp_fwd); end
    total++;
    if (vs2_rdata_o !== exp_v5) begin bad++; $display("FAIL fwd_other_port got=%h want=%h", vs2_rdata_o, exp_v5); end
    vs2_raddr_i = 5'd7;
    #1;
    total++;
    if (vs2_rdata_o !== exp_fwd) begin bad++; $display("FAIL fwd_both_ports got=%h want=%h", vs2_rdata_o, exp_fwd); end
    step();
    idle();
    #1;
    total++;
    if (vs1_rdata_o !== exp_fwd) begin bad++; $display("FAIL fwd_stored got=%h want=%h", vs1_rdata_o, exp_fwd); end
  endtask

  task automatic test_scoreboard();
    issue_valid_i = 1'b1; issue_vd_i = 5'd3;
    vs1_raddr_i = 5'd4; vs2_raddr_i = 5'd3;
    #1;
    total++;
    if (busy_o !== 32'h0) begin bad++; $display("FAIL sb_before_edge got=%h want=0", busy_o); end
    step();
    idle();
    #1;
    total++;
    if (busy_o !== 32'h0000_0008) begin bad++; $display("FAIL sb_set got=%h want=00000008", busy_o); end
    total++;
    if (vs2_busy_o !== 1'b1 || vs1_busy_o !== 1'b0) begin
      bad++; $display("FAIL sb_port_busy got=%b/%b want=0/1", vs1_busy_o, vs2_busy_o);
    end
    // Empty-mask write still retires the producer.
    wen_i = 1'b1; waddr_i = 5'd3; wdata_i = splat(32'hFFFF_FFFF); wmask_i = 8'h00;
    #1;
    total++;
    if (vs2_busy_o !== 1'b0 || busy_o !== 32'h0000_0008) begin
      bad++; $display("FAIL sb_clear_comb got=%b/%h want=0/00000008", vs2_busy_o, busy_o);
    end
    step();
    idle();
    #1;
    total++;
    if (busy_o !== 32'h0 || vs2_rdata_o !== '0) begin
      bad++; $display("FAIL sb_cleared got=%h data=%h want=0/0", busy_o, vs2_rdata_o);
    end
    issue_valid_i = 1'b1; issue_vd_i = 5'd3;
    wen_i = 1'b1; waddr_i = 5'd3; wmask_i = 8'hFF; wdata_i = splat(32'h33);
    step();
    idle();
    #1;
    total++;
    if (busy_o !== 32'h0000_0008) begin bad++; $display("FAIL sb_set_wins got=%h want=00000008", busy_o); end
    issue_valid_i = 1'b1; issue_vd_i = 5'd9;
    wen_i = 1'b1; waddr_i = 5'd3; wmask_i = 8'hFF; wdata_i = splat(32'h44);
    step();
    idle();
    #1;
    total++;
    if (busy_o !== 32'h0000_0200) begin bad++; $display("FAIL sb_diff_regs got=%h want=00000200", busy_o); end
    issue_valid_i = 1'b1; issue_vd_i = 5'd9;
    step();
    idle();
    #1;
    total++;
    if (busy_o !== 32'h0000_0200) begin bad++; $display("FAIL sb_reissue got=%h want=00000200", busy_o); end
  endtask

  task automatic test_async_reset();
    logic [255:0] exp;
    exp = splat(32'hCAFE_0001);
    wen_i = 1'b1; waddr_i = 5'd1; wdata_i = splat(32'h1234_5678); wmask_i = 8'hFF;
    issue_valid_i = 1'b1; issue_vd_i = 5'd2;
    step();
    vs1_raddr_i = 5'd1; vs2_raddr_i = 5'd9;
    wen_i = 1'b1; waddr_i = 5'd1; wdata_i = splat(32'hBAD0_BAD0);
    issue_valid_i = 1'b1; issue_vd_i = 5'd4;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (vs1_rdata_o !== '0 || vs2_rdata_o !== '0) begin
      bad++; $display("FAIL arst_rdata got=%h/%h want=0/0", vs1_rdata_o, vs2_rdata_o);
    end
    total++;
    if (busy_o !== 32'h0 || vs1_busy_o !== 1'b0 || vs2_busy_o !== 1'b0) begin
      bad++; $display("FAIL arst_busy got=%h/%b/%b want=0/0/0", busy_o, vs1_busy_o, vs2_busy_o);
    end
    step();
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    total++;
    if (vs1_rdata_o !== '0 || busy_o !== 32'h0) begin
      bad++; $display("FAIL arst_discard got=%h/%h want=0/0", vs1_rdata_o, busy_o);
    end
    wen_i = 1'b1; waddr_i = 5'd1; wdata_i = exp; wmask_i = 8'hFF;
    step();
    idle();
    #1;
    total++;
    if (vs1_rdata_o !== exp) begin bad++; $display("FAIL arst_first_write got=%h want=%h", vs1_rdata_o, exp); end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_masked_write();
    test_forwarding();
    test_scoreboard();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
